// File: rtl/memory_access_unit_pkg.sv
// Shared types and constants for the RV32I load/store stage.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE,
    SB,
    SH,
    SW,
    LB,
    LH,
    LW,
    LBU,
    LHU
  } mem_op_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

endpackage

// File: rtl/memory_access_unit_lane_align.sv
// Byte/half lane handling: store-side merge of sub-word data into the read
// word, load-side extraction and sign/zero extension. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_op_e     i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_wr_word,
  output logic [31:0] o_ld_data
);

  logic [4:0]        w_byte_base;
  logic [4:0]        w_half_base;
  logic [BYTE_W-1:0] w_byte;
  logic [HALF_W-1:0] w_half;

  assign w_byte_base = {i_off, 3'b000};
  assign w_half_base = {i_off[1], 4'b0000};
  assign w_byte      = i_rd_word[w_byte_base +: BYTE_W];
  assign w_half      = i_rd_word[w_half_base +: HALF_W];

  // Merge store data into the read word, or extract and extend load data.
  always_comb begin
    o_wr_word = '0;
    o_ld_data = '0;
    unique case (i_op)
      SB: begin
        o_wr_word = i_rd_word;
        o_wr_word[w_byte_base +: BYTE_W] = i_st_data[BYTE_W-1:0];
      end
      SH: begin
        o_wr_word = i_rd_word;
        o_wr_word[w_half_base +: HALF_W] = i_st_data[HALF_W-1:0];
      end
      SW:  o_wr_word = i_st_data;
      LB:  o_ld_data = {{(32-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
      LBU: o_ld_data = {{(32-BYTE_W){1'b0}}, w_byte};
      LH:  o_ld_data = {{(32-HALF_W){w_half[HALF_W-1]}}, w_half};
      LHU: o_ld_data = {{(32-HALF_W){1'b0}}, w_half};
      LW:  o_ld_data = i_rd_word;
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// RV32I load/store stage: effective-address adder, strobe priority encoder,
// lane alignment against an async-read word RAM.
// Optional feature macro: MEMORY_ACCESS_MISALIGN_CHECK_EN (sticky misalign
// flag, suppresses misaligned writes and zeroes misaligned load results).
`ifndef MEMORY_DEPTH
`define MEMORY_DEPTH 10
`endif
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif

module memory_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = `MEMORY_DEPTH,
  parameter int unsigned DATA_W = `MEMORY_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rv32_s_sb,
  input  logic              rv32_s_sh,
  input  logic              rv32_s_sw,
  input  logic              rv32_i_lb,
  input  logic              rv32_i_lh,
  input  logic              rv32_i_lw,
  input  logic              rv32_i_lbu,
  input  logic              rv32_i_lhu,
  input  logic [11:0]       rv32_i_imm_11_0,
  input  logic [11:0]       rv32_s_imm_11_0,
  input  logic [31:0]       operand_1,
  input  logic [31:0]       operand_2,
  input  logic [31:0]       operand_3,
  output logic [31:0]       write_back_register_rd_data,
  output logic [ADDR_W-1:0] memory_read_address,
  input  logic [DATA_W-1:0] memory_read_data,
  output logic [ADDR_W-1:0] memory_write_address,
  output logic [DATA_W-1:0] memory_write_data,
  output logic              memory_write_enable,
  output logic              misaligned_error
);

  mem_op_e     w_op;
  logic        w_store;
  logic [11:0] w_imm;
  logic [31:0] w_ea;
  logic [1:0]  w_off;
  logic [31:0] w_wr_word;
  logic [31:0] w_ld_data;
  logic        w_misaligned;

  // Stores beat loads; sw>sh>sb, then lw>lh>lhu>lb>lbu.
  always_comb begin
    w_op = MEM_NONE;
    if      (rv32_s_sw)  w_op = SW;
    else if (rv32_s_sh)  w_op = SH;
    else if (rv32_s_sb)  w_op = SB;
    else if (rv32_i_lw)  w_op = LW;
    else if (rv32_i_lh)  w_op = LH;
    else if (rv32_i_lhu) w_op = LHU;
    else if (rv32_i_lb)  w_op = LB;
    else if (rv32_i_lbu) w_op = LBU;
  end

  assign w_store = rv32_s_sb | rv32_s_sh | rv32_s_sw;
  assign w_imm   = w_store ? rv32_s_imm_11_0 : rv32_i_imm_11_0;
  assign w_ea    = operand_1 + {{20{w_imm[11]}}, w_imm};
  assign w_off   = w_ea[1:0];

  assign memory_read_address  = w_ea[ADDR_W+1:2];
  assign memory_write_address = w_ea[ADDR_W+1:2];

  mem_lane_align u_lane_align (
    .i_op      (w_op),
    .i_off     (w_off),
    .i_rd_word (memory_read_data),
    .i_st_data (operand_2),
    .o_wr_word (w_wr_word),
    .o_ld_data (w_ld_data)
  );

  assign w_misaligned = (((w_op == SH) || (w_op == LH) || (w_op == LHU)) && w_off[0])
                      || (((w_op == SW) || (w_op == LW)) && (w_off != 2'b00));

  assign memory_write_data = w_wr_word;

`ifdef MEMORY_ACCESS_MISALIGN_CHECK_EN
  logic r_misaligned_error;

  assign memory_write_enable         = w_store & ~w_misaligned;
  assign write_back_register_rd_data = w_misaligned ? '0 : w_ld_data;

  // Sticky misalign flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_misaligned_error <= 1'b0;
    else if (w_misaligned) r_misaligned_error <= 1'b1;
  end

  assign misaligned_error = r_misaligned_error;

  logic w_unused;
  assign w_unused = ^operand_3 ^ ^w_ea[31:ADDR_W+2];
`else
  assign memory_write_enable         = w_store;
  assign write_back_register_rd_data = w_ld_data;
  assign misaligned_error            = 1'b0;

  logic w_unused;
  assign w_unused = clk ^ rst_n ^ ^operand_3 ^ ^w_ea[31:ADDR_W+2] ^ w_misaligned;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed self-checking bench for memory_access_unit.
module tb_memory_access_unit;
  import mem_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sb, sh, sw, lb, lh, lw, lbu, lhu;
  logic [11:0]       i_imm, s_imm;
  logic [31:0]       op1, op2, op3;
  logic [31:0]       rd_data;
  logic [ADDR_W-1:0] raddr, waddr;
  logic [DATA_W-1:0] rdata, wdata;
  logic              we, mis;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  memory_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .rv32_s_sb                   (sb),
    .rv32_s_sh                   (sh),
    .rv32_s_sw                   (sw),
    .rv32_i_lb                   (lb),
    .rv32_i_lh                   (lh),
    .rv32_i_lw                   (lw),
    .rv32_i_lbu                  (lbu),
    .rv32_i_lhu                  (lhu),
    .rv32_i_imm_11_0             (i_imm),
    .rv32_s_imm_11_0             (s_imm),
    .operand_1                   (op1),
    .operand_2                   (op2),
    .operand_3                   (op3),
    .write_back_register_rd_data (rd_data),
    .memory_read_address         (raddr),
    .memory_read_data            (rdata),
    .memory_write_address        (waddr),
    .memory_write_data           (wdata),
    .memory_write_enable         (we),
    .misaligned_error            (mis)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clr();
    {sb, sh, sw, lb, lh, lw, lbu, lhu} = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    i_imm = '0; s_imm = '0; op1 = '0; op2 = '0; op3 = 32'hDEAD_BEEF; rdata = '0;
    #12;
    check("reset_mis", {31'd0, mis}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // sb at EA 0 into zero word
    clr(); sb = 1; op1 = 0; s_imm = 12'h000; op2 = 32'h1; rdata = 0; #1;
    check("sb0_waddr", {22'd0, waddr}, 32'd0);
    check("sb0_wdata", wdata, 32'h0000_0001);
    check("sb0_we",    {31'd0, we}, 32'd1);
    check("sb0_rd",    rd_data, 32'd0);

    // sb with negative S-imm: EA=3; I-imm set differently to prove S-imm is used
    clr(); sb = 1; op1 = 32'h5; s_imm = 12'hFFE; i_imm = 12'h100; op2 = 32'hAB;
    rdata = 32'h1122_3344; #1;
    check("sb3_waddr", {22'd0, waddr}, 32'd0);
    check("sb3_wdata", wdata, 32'hAB22_3344);

    // sh into upper half, then off[0] set (ignored by the merge)
    clr(); sh = 1; op1 = 32'h2; s_imm = 0; op2 = 32'h1234_BEEF; #1;
    check("sh2_wdata", wdata, 32'hBEEF_3344);
`ifndef MEMORY_ACCESS_MISALIGN_CHECK_EN
    op1 = 32'h3; #1;
    check("sh3_wdata", wdata, 32'hBEEF_3344);
    check("sh3_we", {31'd0, we}, 32'd1);
`endif

    // sw beats sb; store beats load (rd 0, S-imm used for address)
    clr(); sw = 1; sb = 1; lw = 1; op1 = 32'h10; s_imm = 12'h004; i_imm = 12'h040;
    op2 = 32'hCAFE_BABE; #1;
    check("sw_wdata", wdata, 32'hCAFE_BABE);
    check("sw_waddr", {22'd0, waddr}, 32'd5);
    check("sw_raddr", {22'd0, raddr}, 32'd5);
    check("sw_rd",    rd_data, 32'd0);

    // byte loads, I-imm addressing
    clr(); lb = 1; op1 = 0; i_imm = 12'h002; s_imm = 12'h7FC; rdata = 32'h0080_FF00; #1;
    check("lb2_rd", rd_data, 32'hFFFF_FF80);
    check("lb_we",  {31'd0, we}, 32'd0);
    check("lb_wdata", wdata, 32'd0);
    clr(); lbu = 1; #1;
    check("lbu2_rd", rd_data, 32'h0000_0080);
    clr(); lb = 1; i_imm = 12'h001; #1;
    check("lb1_rd", rd_data, 32'hFFFF_FFFF);
    clr(); lb = 1; lbu = 1; i_imm = 12'h002; rdata = 32'h0080_0000; #1;
    check("lb_prio_rd", rd_data, 32'hFFFF_FF80);
    clr(); lbu = 1; #1;
    check("lbu_b_rd", rd_data, 32'h0000_0080);

    // half loads at EA 6
    clr(); lh = 1; op1 = 32'h4; i_imm = 12'h002; rdata = 32'h8001_1234; #1;
    check("lh6_rd",    rd_data, 32'hFFFF_8001);
    check("lh6_raddr", {22'd0, raddr}, 32'd1);
    clr(); lhu = 1; #1;
    check("lhu6_rd", rd_data, 32'h0000_8001);
    clr(); lhu = 1; lb = 1; op1 = 32'h4; i_imm = 12'h000; #1;
    check("lhu_prio_rd", rd_data, 32'h0000_1234);

    // lw beats lb
    clr(); lw = 1; lb = 1; op1 = 32'h8; i_imm = 0; #1;
    check("lw_rd",    rd_data, 32'h8001_1234);
    check("lw_raddr", {22'd0, raddr}, 32'd2);

    // address wrap and truncation
    clr(); lw = 1; op1 = 32'hFFFF_FFFF; i_imm = 12'h001; #1;
    check("wrap_raddr", {22'd0, raddr}, 32'd0);
    op1 = 32'h0000_1000; i_imm = 12'hFFC; #1;
    check("trunc_raddr", {22'd0, raddr}, 32'd1023);

    // idle
    clr(); op2 = 32'hFFFF_FFFF; #1;
    check("idle_we",    {31'd0, we}, 32'd0);
    check("idle_wdata", wdata, 32'd0);
    check("idle_rd",    rd_data, 32'd0);

    // misaligned sw at EA 2
    @(negedge clk);
    clr(); sw = 1; op1 = 32'h2; s_imm = 0; op2 = 32'h1357_9BDF; #1;
`ifdef MEMORY_ACCESS_MISALIGN_CHECK_EN
    check("missw_we", {31'd0, we}, 32'd0);
    check("missw_flag_pre", {31'd0, mis}, 32'd0);
    @(posedge clk); #1;
    check("missw_flag", {31'd0, mis}, 32'd1);
    clr(); lb = 1; op1 = 0; i_imm = 0; #1;
    @(posedge clk); #1;
    check("mis_sticky", {31'd0, mis}, 32'd1);
    clr(); lh = 1; i_imm = 12'h001; rdata = 32'hFFFF_FFFF; #1;
    check("mislh_rd", rd_data, 32'd0);
    rst_n = 1'b0; #1;
    check("mis_rst", {31'd0, mis}, 32'd0);
    rst_n = 1'b1;
`else
    check("missw_we", {31'd0, we}, 32'd1);
    check("missw_wdata", wdata, 32'h1357_9BDF);
    @(posedge clk); #1;
    check("missw_flag", {31'd0, mis}, 32'd0);
    clr(); lh = 1; op1 = 0; i_imm = 12'h001; rdata = 32'h8001_7FFF; #1;
    check("mislh_rd", rd_data, 32'h0000_7FFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
